// File: rtl/fog_param_pkg.sv
// Shared definitions for the FOG parameter controller: FSM states, register map and power-on defaults.
// Address 4'hF is a command (COMMIT), not a storage location.
package fog_param_pkg;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_SETTLE = 2'd1,
        S_RUN    = 2'd2,
        S_COMMIT = 2'd3
    } fog_state_t;

    localparam int FOG_NUM_REGS = 11;

    localparam logic [3:0] ADDR_FREQ_CNT     = 4'd0;
    localparam logic [3:0] ADDR_AMP_H        = 4'd1;
    localparam logic [3:0] ADDR_AMP_L        = 4'd2;
    localparam logic [3:0] ADDR_POLARITY     = 4'd3;
    localparam logic [3:0] ADDR_WAIT_CNT     = 4'd4;
    localparam logic [3:0] ADDR_ERR_OFFSET   = 4'd5;
    localparam logic [3:0] ADDR_AVG_SEL      = 4'd6;
    localparam logic [3:0] ADDR_GAINSEL_STEP = 4'd7;
    localparam logic [3:0] ADDR_GAINSEL_RAMP = 4'd8;
    localparam logic [3:0] ADDR_FB_ON        = 4'd9;
    localparam logic [3:0] ADDR_CONST_STEP   = 4'd10;
    localparam logic [3:0] ADDR_COMMIT       = 4'hF;

    localparam logic [31:0] FOG_DEFAULTS [FOG_NUM_REGS] = '{
        32'd1000, 32'd5000, 32'd5000, 32'd0,  32'd50, 32'd0,
        32'd10,   32'd5,    32'd10,   32'd1,  32'd100
    };

endpackage

// File: rtl/fog_param_ctrl.sv
// Double-buffered FOG parameter bank: host writes land in a shadow bank and are
// copied to the active bank atomically on the first modulation-period strobe after a COMMIT.
module fog_param_ctrl
    import fog_param_pkg::*;
#(
    parameter logic [31:0] SETTLE_CYCLES = 32'd100000,
    parameter int          NUM_REGS      = FOG_NUM_REGS
) (
    input  logic        CLOCK_CPU,
    input  logic        RST_SYNC,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    input  logic [3:0]  i_wr_addr,
    input  logic [31:0] i_wr_data,
    input  logic [3:0]  i_rd_addr,
    output logic [31:0] o_rd_data,
    input  logic        i_period_strobe,
    output logic [31:0] o_var_freq_cnt,
    output logic [31:0] o_var_amp_H,
    output logic [31:0] o_var_amp_L,
    output logic [31:0] o_var_wait_cnt,
    output logic [31:0] o_var_err_offset,
    output logic [31:0] o_var_avg_sel,
    output logic [31:0] o_var_gainSel_step,
    output logic [31:0] o_var_gainSel_ramp,
    output logic [31:0] o_var_fb_ON,
    output logic [31:0] o_var_const_step,
    output logic        o_var_polarity,
    output logic        o_busy,
    output logic        o_addr_err,
    output logic [1:0]  o_state
);

    fog_state_t  r_state;
    fog_state_t  w_state_nxt;
    logic [31:0] r_settle_cnt;
    logic [31:0] r_shadow [NUM_REGS];
    logic [31:0] r_active [NUM_REGS];
    logic        r_addr_err;
    logic [31:0] r_rd_data;
    logic [31:0] w_rd_nxt;
    logic        w_wr_acc;
    logic        w_is_reg;
    logic        w_is_commit;
    logic        w_settle_done;
    logic        w_apply;

    assign o_wr_ready    = (r_state == S_RUN);
    assign w_wr_acc      = i_wr_valid & o_wr_ready;
    assign w_is_reg      = ({28'd0, i_wr_addr} < 32'(NUM_REGS));
    assign w_is_commit   = (i_wr_addr == ADDR_COMMIT);
    // Widened compare so SETTLE_CYCLES of 0 or 1 both leave after a single cycle.
    assign w_settle_done = (({1'b0, r_settle_cnt} + 33'd1) >= {1'b0, SETTLE_CYCLES});
    assign w_apply       = (r_state == S_COMMIT) & i_period_strobe;

    always_ff @(posedge CLOCK_CPU) begin
        if (RST_SYNC) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:   w_state_nxt = S_SETTLE;
            S_SETTLE: if (w_settle_done) w_state_nxt = S_RUN;
            S_RUN:    if (w_wr_acc && w_is_commit) w_state_nxt = S_COMMIT;
            S_COMMIT: if (i_period_strobe) w_state_nxt = S_RUN;
            default:  w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge CLOCK_CPU) begin
        if (RST_SYNC || r_state != S_SETTLE) begin
            r_settle_cnt <= 32'd0;
        end else if (!w_settle_done) begin
            r_settle_cnt <= r_settle_cnt + 32'd1;
        end
    end

    // Shadow writes are only possible in S_RUN, so shadow is stable while a commit is pending.
    always_ff @(posedge CLOCK_CPU) begin
        if (RST_SYNC || r_state == S_INIT) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= FOG_DEFAULTS[i];
                r_active[i] <= FOG_DEFAULTS[i];
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_acc && i_wr_addr == 4'(i)) begin
                    r_shadow[i] <= (i == int'(ADDR_POLARITY)) ? {31'd0, i_wr_data[0]} : i_wr_data;
                end
                if (w_apply) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    always_ff @(posedge CLOCK_CPU) begin
        if (RST_SYNC) begin
            r_addr_err <= 1'b0;
        end else if (w_wr_acc && !w_is_reg && !w_is_commit) begin
            r_addr_err <= 1'b1;
        end
    end

    always_comb begin
        w_rd_nxt = 32'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_rd_addr == 4'(i)) begin
                w_rd_nxt = r_active[i];
            end
        end
    end

    always_ff @(posedge CLOCK_CPU) begin
        if (RST_SYNC) begin
            r_rd_data <= 32'd0;
        end else begin
            r_rd_data <= w_rd_nxt;
        end
    end

    assign o_var_freq_cnt     = r_active[ADDR_FREQ_CNT];
    assign o_var_amp_H        = r_active[ADDR_AMP_H];
    assign o_var_amp_L        = r_active[ADDR_AMP_L];
    assign o_var_polarity     = r_active[ADDR_POLARITY][0];
    assign o_var_wait_cnt     = r_active[ADDR_WAIT_CNT];
    assign o_var_err_offset   = r_active[ADDR_ERR_OFFSET];
    assign o_var_avg_sel      = r_active[ADDR_AVG_SEL];
    assign o_var_gainSel_step = r_active[ADDR_GAINSEL_STEP];
    assign o_var_gainSel_ramp = r_active[ADDR_GAINSEL_RAMP];
    assign o_var_const_step   = r_active[ADDR_CONST_STEP];
    // Feedback stays off until the loop has settled.
    assign o_var_fb_ON        = (r_state == S_RUN || r_state == S_COMMIT) ? r_active[ADDR_FB_ON] : 32'd0;
    assign o_busy             = (r_state == S_COMMIT);
    assign o_addr_err         = r_addr_err;
    assign o_rd_data          = r_rd_data;
    assign o_state            = r_state;

endmodule

// File: tb/tb_fog_param_ctrl.sv
// Bench for fog_param_ctrl: a cycle-level reference model checked against every output each cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fog_param_ctrl;

    localparam logic [31:0] SETTLE = 32'd10;
    localparam int          RUN_AT = 11;   // cycles after the reset edge: 1 INIT + 10 SETTLE
    localparam logic [31:0] DEFS [11] = '{32'd1000, 32'd5000, 32'd5000, 32'd0, 32'd50, 32'd0,
                                          32'd10, 32'd5, 32'd10, 32'd1, 32'd100};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_addr = 4'd0;
    logic [31:0] wr_data = 32'd0;
    logic [3:0]  rd_addr = 4'd0;
    logic [31:0] rd_data;
    logic        strobe = 1'b0;
    logic [31:0] outs [11];
    logic        polarity, busy, addr_err;
    logic [1:0]  state;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fog_param_ctrl #(.SETTLE_CYCLES(SETTLE), .NUM_REGS(11)) dut (
        .CLOCK_CPU(clk), .RST_SYNC(rst),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data), .i_period_strobe(strobe),
        .o_var_freq_cnt(outs[0]), .o_var_amp_H(outs[1]), .o_var_amp_L(outs[2]),
        .o_var_wait_cnt(outs[4]), .o_var_err_offset(outs[5]), .o_var_avg_sel(outs[6]),
        .o_var_gainSel_step(outs[7]), .o_var_gainSel_ramp(outs[8]), .o_var_fb_ON(outs[9]),
        .o_var_const_step(outs[10]), .o_var_polarity(polarity),
        .o_busy(busy), .o_addr_err(addr_err), .o_state(state)
    );
    assign outs[3] = {31'd0, polarity};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: active/shadow banks, pending-commit flag, cycles since reset.
    logic [31:0] m_shadow [11];
    logic [31:0] m_active [11];
    logic        m_pending = 1'b0;
    logic        m_err = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_rd = 32'd0;
    int          m_since = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) begin
                m_shadow[i] = DEFS[i];
                m_active[i] = DEFS[i];
            end
            m_pending = 1'b0;
            m_err     = 1'b0;
            m_rd      = 32'd0;
            m_since   = 0;
            m_valid   = 1'b1;
        end else if (m_valid) begin
            m_rd = (rd_addr < 4'd11) ? m_active[rd_addr] : 32'd0;
            if (m_since >= RUN_AT) begin
                if (!m_pending && wr_valid) begin
                    if (wr_addr < 4'd11)
                        m_shadow[wr_addr] = (wr_addr == 4'd3) ? {31'd0, wr_data[0]} : wr_data;
                    else if (wr_addr == 4'hF)
                        m_pending = 1'b1;
                    else
                        m_err = 1'b1;
                end else if (m_pending && strobe) begin
                    for (int i = 0; i < 11; i++) m_active[i] = m_shadow[i];
                    m_pending = 1'b0;
                end
            end
            if (m_since < 100000) m_since++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < 11; i++) begin
                if (i == 9)
                    chk("model_fb_ON", outs[9], (m_since >= RUN_AT) ? m_active[9] : 32'd0);
                else
                    chk($sformatf("model_out%0d", i), outs[i], m_active[i]);
            end
            chk("model_busy",  {31'd0, busy},     {31'd0, m_pending});
            chk("model_ready", {31'd0, wr_ready}, {31'd0, (m_since >= RUN_AT) && !m_pending});
            chk("model_err",   {31'd0, addr_err}, {31'd0, m_err});
            chk("model_rd",    rd_data, m_rd);
            chk("model_state", {30'd0, state},
                (m_since == 0) ? 32'd0 : (m_since < RUN_AT) ? 32'd1 : m_pending ? 32'd3 : 32'd2);
        end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic s);
        @(posedge clk); #2;
        wr_valid = 1'b1; wr_addr = a; wr_data = d; strobe = s;
        @(posedge clk); #2;
        wr_valid = 1'b0; strobe = 1'b0;
    endtask

    task automatic pulse();
        @(posedge clk); #2 strobe = 1'b1;
        @(posedge clk); #2 strobe = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Power-up: INIT, then 10 settle cycles with feedback forced off.
        @(negedge clk);
        chk("init_state", {30'd0, state}, 32'd0);
        chk("init_ready", {31'd0, wr_ready}, 32'd0);
        chk("init_rd",    rd_data, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("settle_fb", outs[9], 32'd0);
        end
        @(negedge clk);
        chk("run_fb",   outs[9], 32'd1);
        chk("run_freq", outs[0], 32'd1000);

        // Commit held off until the period strobe.
        wr(4'd0, 32'd2000, 1'b0);
        wr(4'hF, 32'd0, 1'b0);
        @(negedge clk);
        chk("commit_busy", {31'd0, busy}, 32'd1);
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("wait_freq", outs[0], 32'd1000);
        chk("wait_busy", {31'd0, busy}, 32'd1);
        pulse();
        @(negedge clk);
        chk("apply_freq", outs[0], 32'd2000);
        chk("apply_busy", {31'd0, busy}, 32'd0);

        // Two registers change together; strobe coincident with COMMIT is ignored.
        wr(4'd1, 32'd6000, 1'b0);
        wr(4'd2, 32'd4000, 1'b0);
        wr(4'hF, 32'd0, 1'b1);
        @(negedge clk);
        chk("coinc_busy", {31'd0, busy}, 32'd1);
        chk("coinc_ampH", outs[1], 32'd5000);
        repeat (3) @(posedge clk);
        pulse();
        @(negedge clk);
        chk("pair_ampH", outs[1], 32'd6000);
        chk("pair_ampL", outs[2], 32'd4000);
        pulse();   // strobe while running: no effect

        // Invalid address.
        wr(4'd12, 32'd5, 1'b0);
        @(negedge clk);
        chk("bad_err",  {31'd0, addr_err}, 32'd1);
        chk("bad_freq", outs[0], 32'd2000);

        // Polarity keeps bit 0 only; readback latency and unmapped reads.
        wr(4'd3, 32'hFFFF_FFFF, 1'b0);
        wr(4'hF, 32'd0, 1'b0);
        pulse();
        @(posedge clk); #2 rd_addr = 4'd3;
        @(posedge clk);
        @(negedge clk);
        chk("rd_polarity", rd_data, 32'd1);
        chk("out_polarity", {31'd0, polarity}, 32'd1);
        #2 rd_addr = 4'd13;
        @(posedge clk);
        @(negedge clk);
        chk("rd_unmapped", rd_data, 32'd0);
        #2 rd_addr = 4'd1;
        @(posedge clk);
        @(negedge clk);
        chk("rd_ampH", rd_data, 32'd6000);

        // Reset while a commit is pending.
        wr(4'd0, 32'd3000, 1'b0);
        wr(4'hF, 32'd0, 1'b0);
        @(negedge clk);
        chk("pend_busy", {31'd0, busy}, 32'd1);
        do_reset();
        @(negedge clk);
        chk("rst_freq", outs[0], 32'd1000);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err",  {31'd0, addr_err}, 32'd0);
        chk("rst_ampH", outs[1], 32'd5000);
        repeat (12) @(posedge clk);
        pulse();
        @(negedge clk);
        chk("post_rst_freq", outs[0], 32'd1000);
        chk("post_rst_fb",   outs[9], 32'd1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
